traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
- Passive checker on the observing side of the traffic-light controller outputs. It samples both directions' lamp vectors on a prescaled tick.
- Tracks each direction with a shadow FSM and flags malformed, conflicting, out-of-sequence or too-short phases.
- Errors are sticky and readable by test logic or a debug port. It also counts completed direction-A cycles.
- Sits beside the traffic-light core in the top-level wrapper; it never drives the lamps.

Parameters:
- MIN_GREEN, 4, minimum number of samples a direction must stay GREEN.
- MIN_YELLOW, 2, minimum number of samples a direction must stay YELLOW.
- DWELL_W, 8, width of the per-direction dwell counters, saturating.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sample_en  input  1  one-cycle tick; lamps are evaluated only on cycles where this is 1.
- lights_a  input  3  direction A lamps {red, yellow, green}.
- lights_b  input  3  direction B lamps {red, yellow, green}.
- err_clear  input  1  clears the sticky error flags and first_err.
- err_flags  output  4  sticky {timing, seq, conflict, onehot}.
- err_any  output  1  OR of err_flags.
- first_err  output  3  code of the first error since reset/clear: 0 none, 1 onehot, 2 conflict, 3 seq, 4 timing.
- cycle_cnt  output  8  count of direction-A RED->GREEN transitions, saturating at 255.

Behaviour:
- Reset (asynchronous, active-high):
  - err_flags=0, err_any=0, first_err=0, cycle_cnt=0.
  - Both shadow FSMs go to UNKNOWN; dwell counters go to 0.
- Evaluation timing:
  - All evaluation occurs on the rising clk edge where sample_en=1. Cycles with sample_en=0 change nothing except err_clear handling.
  - Results are visible the cycle after the sampling edge, i.e. latency is 1 clk.
- Per-direction FSM, states UNKNOWN, RED, YELLOW, GREEN:
  - A sample is valid iff exactly one lamp bit is set.
  - Invalid sample: set onehot; FSM goes to UNKNOWN; dwell counter goes to 0.
  - UNKNOWN + valid sample: adopt that colour, dwell=1, no sequence or timing check (resync).
  - Same colour as the current state: dwell increments, saturating at 2^DWELL_W-1.
  - Legal changes are RED->GREEN, GREEN->YELLOW, YELLOW->RED. Any other colour change sets seq; the FSM still adopts the new colour with dwell=1.
  - Leaving GREEN with dwell<MIN_GREEN, or leaving YELLOW with dwell<MIN_YELLOW, sets timing. This applies whether or not the transition itself is legal.
  - Dwell counts samples in the state, including the entering sample.
- Conflict: on a sample where both directions are valid and neither is RED, set conflict. This is checked on the raw sample, independent of FSM state.
- cycle_cnt: increments on a legal RED->GREEN transition of direction A only; holds at 255. It is unaffected by err_clear.
- first_err:
  - Loaded only while it is 0 and at least one flag is being newly set that edge.
  - When several errors set on the same edge, the lowest code wins (onehot > conflict > seq > timing).
- err_clear:
  - Synchronous; clears err_flags and first_err on the next edge.
  - If err_clear and a new error occur on the same edge, the new error is recorded: the flag is set and first_err is loaded with its code.
  - err_clear does not affect FSMs, dwell counters or cycle_cnt.
- err_any is the combinational OR of the registered err_flags.
- Reset asserted mid-sequence aborts everything immediately. After release, the first valid sample per direction resyncs with no error.

Test Plan:
- Legal traffic, MIN_GREEN=4, MIN_YELLOW=2. Reset, then sample stream:
  - A: R x3, G x4, Y x2, R x6, G x4.
  - B: G/Y whenever A is R; B is R whenever A is non-R.
  - Required: err_flags=0, first_err=0, cycle_cnt=2.
- Short yellow: A sequence G x4, Y x1, R.
  - Required: err_flags=4'b1000 one cycle after the R sample, first_err=4, err_any=1.
- Illegal jump: A R then Y.
  - Required: seq set, first_err=3, A FSM now YELLOW.
  - A following R after Y x2 produces no further error.
- Conflict plus multi-hot on the same sample: A=3'b011, B=3'b001.
  - Required: onehot set; no conflict, because A is invalid.
  - Next sample A=3'b001, B=3'b001: conflict set; first_err stays 1.
- err_clear on the same edge as a new timing error.
  - Required: err_flags=4'b1000, first_err=4.
  - err_clear alone afterwards gives err_flags=0, first_err=0, with cycle_cnt unchanged.
- Gating and reset:
  - sample_en held 0 while lamps toggle illegally: no state or flag change.
  - rst pulsed mid-GREEN: all outputs 0 asynchronously.
  - The next sample of Y resyncs without seq or timing error.
  - 300 legal A cycles: cycle_cnt saturates at 255.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive monitor for a two-direction traffic-light controller: shadow FSMs per
// direction, sticky error flags with first-error capture, and an A-cycle counter.
module traffic_light_monitor #(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int DWELL_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic [2:0] lights_a,
  input  logic [2:0] lights_b,
  input  logic       err_clear,
  output logic [3:0] err_flags,
  output logic       err_any,
  output logic [2:0] first_err,
  output logic [7:0] cycle_cnt,
  output logic [1:0] dbg_state_a,
  output logic [1:0] dbg_state_b
);

  typedef enum logic [1:0] {
    S_UNKNOWN = 2'd0,
    S_RED     = 2'd1,
    S_YELLOW  = 2'd2,
    S_GREEN   = 2'd3
  } state_e;

  typedef struct packed {
    state_e             state;
    logic [DWELL_W-1:0] dwell;
    logic               valid;
    logic               not_red;
    logic               seq;
    logic               timing;
    logic               r2g;
  } eval_t;

  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
  localparam logic [DWELL_W-1:0] MIN_G     = DWELL_W'(MIN_GREEN);
  localparam logic [DWELL_W-1:0] MIN_Y     = DWELL_W'(MIN_YELLOW);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  // Next state of one shadow FSM for a single sample, plus the errors it raises.
  function automatic eval_t eval_dir(input state_e st, input logic [DWELL_W-1:0] dw,
                                     input logic [2:0] lamps);
    eval_t  r;
    state_e col;
    logic   legal;
    r       = '0;
    r.state = st;
    r.dwell = dw;
    legal   = 1'b0;
    case (lamps)
      3'b100:  col = S_RED;
      3'b010:  col = S_YELLOW;
      3'b001:  col = S_GREEN;
      default: col = S_UNKNOWN;
    endcase
    r.valid   = (col != S_UNKNOWN);
    r.not_red = r.valid && (col != S_RED);
    if (!r.valid) begin
      r.state = S_UNKNOWN;
      r.dwell = '0;
    end else if (st == S_UNKNOWN) begin
      r.state = col;
      r.dwell = DWELL_ONE;
    end else if (col == st) begin
      if (dw != DWELL_MAX) r.dwell = dw + DWELL_ONE;
    end else begin
      legal    = (st == S_RED && col == S_GREEN) || (st == S_GREEN && col == S_YELLOW) ||
                 (st == S_YELLOW && col == S_RED);
      r.seq    = !legal;
      r.timing = (st == S_GREEN && dw < MIN_G) || (st == S_YELLOW && dw < MIN_Y);
      r.r2g    = (st == S_RED && col == S_GREEN);
      r.state  = col;
      r.dwell  = DWELL_ONE;
    end
    return r;
  endfunction

  state_e             state_a_q, state_a_d, state_b_q, state_b_d;
  logic [DWELL_W-1:0] dwell_a_q, dwell_a_d, dwell_b_q, dwell_b_d;
  logic [3:0]         flags_q, flags_d, flags_base, new_err;
  logic [2:0]         first_q, first_d, first_base;
  logic [7:0]         cycle_q, cycle_d;
  eval_t              ev_a, ev_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_a_q <= S_UNKNOWN;
      state_b_q <= S_UNKNOWN;
      dwell_a_q <= '0;
      dwell_b_q <= '0;
      flags_q   <= '0;
      first_q   <= '0;
      cycle_q   <= '0;
    end else begin
      state_a_q <= state_a_d;
      state_b_q <= state_b_d;
      dwell_a_q <= dwell_a_d;
      dwell_b_q <= dwell_b_d;
      flags_q   <= flags_d;
      first_q   <= first_d;
      cycle_q   <= cycle_d;
    end
  end

  always_comb begin
    ev_a      = eval_dir(state_a_q, dwell_a_q, lights_a);
    ev_b      = eval_dir(state_b_q, dwell_b_q, lights_b);
    state_a_d = state_a_q;
    state_b_d = state_b_q;
    dwell_a_d = dwell_a_q;
    dwell_b_d = dwell_b_q;
    cycle_d   = cycle_q;
    new_err   = '0;
    if (sample_en) begin
      state_a_d = ev_a.state;
      state_b_d = ev_b.state;
      dwell_a_d = ev_a.dwell;
      dwell_b_d = ev_b.dwell;
      // Conflict looks only at the raw sample; an invalid lamp vector cannot conflict.
      new_err   = {ev_a.timing | ev_b.timing, ev_a.seq | ev_b.seq,
                   ev_a.not_red & ev_b.not_red, !ev_a.valid | !ev_b.valid};
      if (ev_a.r2g && cycle_q != 8'hFF) cycle_d = cycle_q + 8'd1;
    end
    // A clear and a fresh error on the same edge keep the fresh error.
    flags_base = err_clear ? 4'd0 : flags_q;
    first_base = err_clear ? 3'd0 : first_q;
    flags_d    = flags_base | new_err;
    first_d    = first_base;
    if (first_base == 3'd0) begin
      if (new_err[0])      first_d = 3'd1;
      else if (new_err[1]) first_d = 3'd2;
      else if (new_err[2]) first_d = 3'd3;
      else if (new_err[3]) first_d = 3'd4;
    end
  end

  assign err_flags   = flags_q;
  assign err_any     = |flags_q;
  assign first_err   = first_q;
  assign cycle_cnt   = cycle_q;
  assign dbg_state_a = state_a_q;
  assign dbg_state_b = state_b_q;

endmodule
